// File: rtl/fp_align_stage.sv
// fp_addr front end: unpack, compare and align two operands.
// Two registered stages with a valid/ready handshake on each side.
module fp_align_stage #(
    parameter int EXP_W = 5,
    parameter int MAN_W = 10,
    localparam int W = 1 + EXP_W + MAN_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [W-1:0]       op_a,
    input  logic [W-1:0]       op_b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               sign_a,
    output logic               sign_b,
    output logic               exp_diff_sig,
    output logic               mant_diff_sig,
    output logic [3:0]         exp_diff,
    output logic               eff_sub,
    output logic [EXP_W-1:0]   big_exp,
    output logic [MAN_W+3:0]   big_mant,
    output logic [MAN_W+3:0]   small_mant,
    output logic               special
);

    localparam int FW = MAN_W + 1;
    localparam int MW = MAN_W + 4;

    typedef struct packed {
        logic             sa;
        logic             sb;
        logic [EXP_W-1:0] ea;
        logic [EXP_W-1:0] eb;
        logic [FW-1:0]    ma;
        logic [FW-1:0]    mb;
        logic             eds;
        logic             mds;
        logic [EXP_W-1:0] d;
        logic [3:0]       ed;
        logic             spec;
    } s1_t;

    typedef struct packed {
        logic             sa;
        logic             sb;
        logic             eds;
        logic             mds;
        logic [3:0]       ed;
        logic             esub;
        logic [EXP_W-1:0] bexp;
        logic [MW-1:0]    bm;
        logic [MW-1:0]    sm;
        logic             spec;
    } s2_t;

    s1_t  s1_q, s1_d, s1_new;
    s2_t  s2_q, s2_d, s2_new;
    logic s1_v_q, s1_v_d;
    logic s2_v_q, s2_v_d;
    logic s1_load, s2_load;

    logic [EXP_W-1:0] fa, fb;
    logic             ha, hb;

    assign s2_load  = !s2_v_q || out_ready;
    assign s1_load  = !s1_v_q || s2_load;
    assign in_ready = s1_load;

    assign fa = op_a[W-2:MAN_W];
    assign fb = op_b[W-2:MAN_W];
    assign ha = |fa;
    assign hb = |fb;

    always_comb begin
        s1_new      = '0;
        s1_new.sa   = op_a[W-1];
        s1_new.sb   = op_b[W-1];
        s1_new.ea   = ha ? fa : EXP_W'(1);
        s1_new.eb   = hb ? fb : EXP_W'(1);
        s1_new.ma   = {ha, op_a[MAN_W-1:0]};
        s1_new.mb   = {hb, op_b[MAN_W-1:0]};
        s1_new.eds  = s1_new.eb > s1_new.ea;
        s1_new.mds  = s1_new.mb > s1_new.ma;
        s1_new.d    = s1_new.eds ? (s1_new.eb - s1_new.ea)
                                 : (s1_new.ea - s1_new.eb);
        s1_new.ed   = (int'(s1_new.d) > 15) ? 4'hF : s1_new.d[3:0];
        s1_new.spec = (&fa) | (&fb);
    end

    always_comb begin
        s1_v_d = s1_v_q;
        s1_d   = s1_q;
        if (s1_load) begin
            s1_v_d = in_valid;
            if (in_valid) s1_d = s1_new;
        end
    end

    logic          swap;
    logic          sticky;
    logic [MW-1:0] ext;
    logic [MW-1:0] sh;

    always_comb begin
        swap   = s1_q.eds | ((s1_q.ea == s1_q.eb) & s1_q.mds);
        ext    = {(swap ? s1_q.ma : s1_q.mb), 3'b000};
        sticky = 1'b0;
        sh     = '0;
        // Shifts past the whole field collapse to a lone sticky bit.
        if (int'(s1_q.d) >= MW) begin
            sh[0] = |ext;
        end else begin
            sh = ext >> s1_q.d;
            for (int i = 0; i < MW; i++) begin
                if (i < int'(s1_q.d)) sticky = sticky | ext[i];
            end
            sh[0] = sh[0] | sticky;
        end

        s2_new      = '0;
        s2_new.sa   = s1_q.sa;
        s2_new.sb   = s1_q.sb;
        s2_new.eds  = s1_q.eds;
        s2_new.mds  = s1_q.mds;
        s2_new.ed   = s1_q.ed;
        s2_new.esub = s1_q.sa ^ s1_q.sb;
        s2_new.bexp = swap ? s1_q.eb : s1_q.ea;
        s2_new.bm   = {(swap ? s1_q.mb : s1_q.ma), 3'b000};
        s2_new.sm   = sh;
        s2_new.spec = s1_q.spec;
    end

    always_comb begin
        s2_v_d = s2_v_q;
        s2_d   = s2_q;
        if (s2_load) begin
            s2_v_d = s1_v_q;
            if (s1_v_q) s2_d = s2_new;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v_q <= 1'b0;
            s2_v_q <= 1'b0;
            s1_q   <= '0;
            s2_q   <= '0;
        end else begin
            s1_v_q <= s1_v_d;
            s2_v_q <= s2_v_d;
            s1_q   <= s1_d;
            s2_q   <= s2_d;
        end
    end

    assign out_valid     = s2_v_q;
    assign sign_a        = s2_q.sa;
    assign sign_b        = s2_q.sb;
    assign exp_diff_sig  = s2_q.eds;
    assign mant_diff_sig = s2_q.mds;
    assign exp_diff      = s2_q.ed;
    assign eff_sub       = s2_q.esub;
    assign big_exp       = s2_q.bexp;
    assign big_mant      = s2_q.bm;
    assign small_mant    = s2_q.sm;
    assign special       = s2_q.spec;

endmodule

// File: tb/tb_fp_align_stage.sv
// Directed bench for fp_align_stage: datapath vectors,
// backpressure ordering and asynchronous reset.
module tb_fp_align_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] op_a, op_b;
    logic        out_valid;
    logic        out_ready;
    logic        sign_a, sign_b;
    logic        exp_diff_sig, mant_diff_sig;
    logic [3:0]  exp_diff;
    logic        eff_sub;
    logic [4:0]  big_exp;
    logic [13:0] big_mant, small_mant;
    logic        special;

    int errors = 0;
    int checks = 0;

    fp_align_stage dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .op_a(op_a), .op_b(op_b),
        .out_valid(out_valid), .out_ready(out_ready),
        .sign_a(sign_a), .sign_b(sign_b),
        .exp_diff_sig(exp_diff_sig), .mant_diff_sig(mant_diff_sig),
        .exp_diff(exp_diff), .eff_sub(eff_sub),
        .big_exp(big_exp), .big_mant(big_mant),
        .small_mant(small_mant), .special(special)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic run_vec(input string tag,
                           input logic [15:0] a, input logic [15:0] b,
                           input logic esa, input logic esb,
                           input logic eds, input logic emds,
                           input logic [3:0] ed, input logic esub,
                           input logic [4:0] bexp,
                           input logic [13:0] bm, input logic [13:0] sm,
                           input logic spec);
        @(negedge clk);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        op_a      = a;
        op_b      = b;
        #1 check({tag, "_in_ready"}, in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
        check({tag, "_lat1"}, out_valid, 0);
        @(negedge clk);
        check({tag, "_valid"}, out_valid, 1);
        check({tag, "_sign_a"}, sign_a, esa);
        check({tag, "_sign_b"}, sign_b, esb);
        check({tag, "_eds"}, exp_diff_sig, eds);
        check({tag, "_mds"}, mant_diff_sig, emds);
        check({tag, "_ed"}, exp_diff, ed);
        check({tag, "_esub"}, eff_sub, esub);
        check({tag, "_bexp"}, big_exp, bexp);
        check({tag, "_bmant"}, big_mant, bm);
        check({tag, "_smant"}, small_mant, sm);
        check({tag, "_special"}, special, spec);
    endtask

    logic [15:0] pa [4];
    int tx, rx;

    initial begin
        #100000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        op_a      = '0;
        op_b      = '0;
        #12;
        check("rst_out_valid", out_valid, 0);
        check("rst_big_mant", big_mant, 0);
        check("rst_small_mant", small_mant, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1 check("rst_in_ready", in_ready, 1);

        run_vec("diffexp", 16'h3C00, 16'h4000,
                0, 0, 1, 0, 4'd1, 0, 5'd16, 14'h2000, 14'h1000, 0);
        run_vec("eqexp", 16'h3E00, 16'hBC00,
                0, 1, 0, 0, 4'd0, 1, 5'd15, 14'h3000, 14'h2000, 0);
        run_vec("tie", 16'h3C00, 16'hBC00,
                0, 1, 0, 0, 4'd0, 1, 5'd15, 14'h2000, 14'h2000, 0);
        run_vec("mswap", 16'h3C00, 16'h3E00,
                0, 0, 0, 1, 4'd0, 0, 5'd15, 14'h3000, 14'h2000, 0);
        run_vec("sat", 16'h7800, 16'h0001,
                0, 0, 0, 0, 4'd15, 0, 5'd30, 14'h2000, 14'h0001, 0);
        run_vec("inf", 16'h7C00, 16'h3C00,
                0, 0, 0, 0, 4'd15, 0, 5'd31, 14'h2000, 14'h0001, 1);
        run_vec("sticky", 16'h4C00, 16'h3C01,
                0, 0, 0, 1, 4'd4, 0, 5'd19, 14'h2000, 14'h0201, 0);
        run_vec("denorm", 16'h0001, 16'h0002,
                0, 0, 0, 1, 4'd0, 0, 5'd1, 14'h0010, 14'h0008, 0);
        run_vec("d13", 16'h7000, 16'h3C00,
                0, 0, 0, 0, 4'd13, 0, 5'd28, 14'h2000, 14'h0001, 0);

        pa[0] = 16'h4000;
        pa[1] = 16'h4400;
        pa[2] = 16'h4800;
        pa[3] = 16'h4C00;
        tx = 0;
        rx = 0;
        for (int cyc = 0; cyc < 12; cyc++) begin
            @(negedge clk);
            out_ready = (cyc >= 5);
            in_valid  = (tx < 4);
            op_a      = (tx < 4) ? pa[tx] : 16'h0;
            op_b      = 16'h3C00;
            #1;
            if (cyc == 2) check("bp_accepted", tx, 2);
            if (cyc >= 2 && cyc <= 4) begin
                check("bp_in_ready", in_ready, 0);
                check("bp_hold_valid", out_valid, 1);
                check("bp_hold_data", big_exp, 16);
            end
            if (out_valid && out_ready) begin
                check("bp_order", big_exp, 16 + rx);
                check("bp_rate", cyc, 5 + rx);
                rx++;
            end
            if (in_valid && in_ready) tx++;
        end
        check("bp_tx", tx, 4);
        check("bp_rx", rx, 4);
        check("bp_drained", out_valid, 0);

        run_vec("pre_rst", 16'h3C00, 16'h4000,
                0, 0, 1, 0, 4'd1, 0, 5'd16, 14'h2000, 14'h1000, 0);
        out_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_bexp", big_exp, 0);
        check("mid_rst_bmant", big_mant, 0);
        check("mid_rst_smant", small_mant, 0);
        check("mid_rst_ed", exp_diff, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1 check("post_rst_ready", in_ready, 1);
        run_vec("post_rst", 16'h3E00, 16'hBC00,
                0, 1, 0, 0, 4'd0, 1, 5'd15, 14'h3000, 14'h2000, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
